// File: rtl/nibble_serial_add_ctrl.sv
// Multi-nibble adder sequencer: drives an external 4-bit adder one nibble per clock, LSB first.
// Optional `OVERFLOW_FLAG_EN adds out_ovf (two's-complement signed overflow of the result).
module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4,
   localparam int W = 4*NIBBLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_cout,
`ifdef OVERFLOW_FLAG_EN
   output logic         out_ovf,
`endif
   output logic         busy,
   output logic [3:0]   adder_a,
   output logic [3:0]   adder_b,
   output logic         adder_cin,
   input  logic [3:0]   adder_sum,
   input  logic         adder_cout
);

   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                   state, state_nxt;
   logic [NIBBLES-1:0][3:0]  a_lat, b_lat, sum_reg, sum_fin;
   logic [IW-1:0]            idx;
   logic                     carry;
   logic                     last;
   logic [W-1:0]             res_sum;
   logic                     res_cout;

   assign last     = (idx == IW'(NIBBLES-1));
   assign out_sum  = res_sum;
   assign out_cout = res_cout;

   // Working sum with the current nibble merged in; captured whole on the last RUN edge.
   always_comb begin
      sum_fin      = sum_reg;
      sum_fin[idx] = adder_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      adder_a   = 4'h0;
      adder_b   = 4'h0;
      adder_cin = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            busy      = 1'b1;
            adder_a   = a_lat[idx];
            adder_b   = b_lat[idx];
            adder_cin = carry;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Result registers are separate from the working sum so out_sum holds through the next RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_lat    <= '0;
         b_lat    <= '0;
         sum_reg  <= '0;
         idx      <= '0;
         carry    <= 1'b0;
         res_sum  <= '0;
         res_cout <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_lat <= in_a;
               b_lat <= in_b;
               carry <= in_cin;
               idx   <= '0;
            end
            RUN: begin
               sum_reg <= sum_fin;
               carry   <= adder_cout;
               if (last) begin
                  res_sum  <= sum_fin;
                  res_cout <= adder_cout;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef OVERFLOW_FLAG_EN
   logic res_ovf;
   assign out_ovf = res_ovf;

   // On the last RUN edge adder_sum is the most-significant nibble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         res_ovf <= 1'b0;
      else if (state == RUN && last)
         res_ovf <= (a_lat[NIBBLES-1][3] == b_lat[NIBBLES-1][3]) &&
                    (adder_sum[3] != a_lat[NIBBLES-1][3]);
   end
`endif

endmodule
